// File: rtl/lfsr_offset_search.sv
// Multi-polynomial Fibonacci LFSR offset finder: steps NUM_POLY LFSRs from SEED until one equals data.
// Optional abort input is compiled in when LFSR_SEARCH_ABORT_EN is defined.
module lfsr_offset_search #(
   parameter int unsigned      WIDTH     = 17,
   parameter int unsigned      NUM_POLY  = 4,
   parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
   parameter int unsigned      MAX_STEPS = 2**WIDTH - 1,
   localparam int unsigned     IDX_W     = (NUM_POLY > 1) ? $clog2(NUM_POLY) : 1
) (
   input  logic                      clk_96MHz,
   input  logic                      reset,
   input  logic                      start,
`ifdef LFSR_SEARCH_ABORT_EN
   input  logic                      abort,
`endif
   input  logic [WIDTH-1:0]          data,
   input  logic [NUM_POLY*WIDTH-1:0] polynomials,
   output logic                      busy,
   output logic                      done,
   output logic                      found,
   output logic [IDX_W-1:0]          poly_index,
   output logic [WIDTH-1:0]          offset
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_STEPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] r_poly       [NUM_POLY];
   logic [WIDTH-1:0] r_lfsr       [NUM_POLY];
   logic [WIDTH-1:0] w_lfsr_next  [NUM_POLY];
   logic [WIDTH-1:0] r_count;
   logic             r_found;
   logic [IDX_W-1:0] r_index;
   logic [WIDTH-1:0] r_offset;
   logic             w_match;
   logic [IDX_W-1:0] w_idx;
   logic             w_abort;
   logic             w_accept;
   logic             w_step;
   logic             w_finish;
   logic             w_hit;

`ifdef LFSR_SEARCH_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   // An all-zero tap mask marks an unused channel: it holds SEED instead of shifting.
   always_comb begin
      for (int unsigned i = 0; i < NUM_POLY; i++) begin
         w_lfsr_next[i] = r_lfsr[i];
         if (r_poly[i] != '0)
            w_lfsr_next[i] = {r_lfsr[i][WIDTH-2:0], ^(r_lfsr[i] & r_poly[i])};
      end
   end

   always_comb begin
      w_match = 1'b0;
      w_idx   = '0;
      for (int unsigned i = 0; i < NUM_POLY; i++) begin
         if (!w_match && (r_lfsr[i] == r_data)) begin
            w_match = 1'b1;
            w_idx   = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk_96MHz or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_step       = 1'b0;
      w_finish     = 1'b0;
      w_hit        = 1'b0;
      busy         = (r_state != S_IDLE);
      done         = (r_state == S_DONE);
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = S_SEARCH;
            end
         end
         S_SEARCH: begin
            if (w_abort) begin
               w_finish     = 1'b1;
               w_state_next = S_DONE;
            end else if (w_match) begin
               w_finish     = 1'b1;
               w_hit        = 1'b1;
               w_state_next = S_DONE;
            end else if (r_count == LAST) begin
               w_finish     = 1'b1;
               w_state_next = S_DONE;
            end else begin
               w_step = 1'b1;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_96MHz or posedge reset) begin
      if (reset) begin
         r_data   <= '0;
         r_count  <= '0;
         r_found  <= 1'b0;
         r_index  <= '0;
         r_offset <= '0;
         for (int unsigned i = 0; i < NUM_POLY; i++) begin
            r_poly[i] <= '0;
            r_lfsr[i] <= SEED;
         end
      end else begin
         if (w_accept) begin
            r_data   <= data;
            r_count  <= '0;
            r_found  <= 1'b0;
            r_index  <= '0;
            r_offset <= '0;
            for (int unsigned i = 0; i < NUM_POLY; i++) begin
               r_poly[i] <= polynomials[i*WIDTH +: WIDTH];
               r_lfsr[i] <= SEED;
            end
         end
         if (w_step) begin
            r_count <= r_count + WIDTH'(1);
            for (int unsigned i = 0; i < NUM_POLY; i++)
               r_lfsr[i] <= w_lfsr_next[i];
         end
         if (w_finish) begin
            r_found  <= w_hit;
            r_index  <= w_hit ? w_idx : '0;
            r_offset <= w_hit ? r_count : '0;
         end
      end
   end

   assign found      = r_found;
   assign poly_index = r_index;
   assign offset     = r_offset;

endmodule

// File: tb/tb_lfsr_offset_search.sv
// Scoreboard bench for lfsr_offset_search: WIDTH=4, two channels (taps 4'hC and an unused all-zero mask).
module tb_lfsr_offset_search;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] data;
   logic [7:0] polys;
   logic       busy, done, found;
   logic [0:0] poly_index;
   logic [3:0] offset;
`ifdef LFSR_SEARCH_ABORT_EN
   logic       abort = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       f;
      logic [0:0] idx;
      logic [3:0] off;
      int         lat;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   lfsr_offset_search #(
      .WIDTH(4),
      .NUM_POLY(2),
      .SEED(4'h1),
      .MAX_STEPS(15)
   ) dut (
      .clk_96MHz(clk),
      .reset(rst),
      .start(start),
`ifdef LFSR_SEARCH_ABORT_EN
      .abort(abort),
`endif
      .data(data),
      .polynomials(polys),
      .busy(busy),
      .done(done),
      .found(found),
      .poly_index(poly_index),
      .offset(offset)
   );

   // Pulse start for one edge; returns just after that (accepting) edge.
   task automatic accept(input logic [3:0] d);
      data  = d;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Counts edges since accept (accept edge = 1) until done is seen, bounded.
   task automatic wait_done(input int n0, output int n);
      n = n0;
      while (done !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, found, poly_index, offset} !== 8'h00) begin
         failures++;
         $display("FAIL reset_state got=%b exp=%b", {busy, done, found, poly_index, offset}, 8'h00);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_match();
      exp_t e; int n;
      sb.push_back('{f:1'b1, idx:1'b0, off:4'h7, lat:9});
      accept(4'hA);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL match_busy got=%b exp=1", busy); end
      wait_done(1, n);
      e = sb.pop_front();
      checks++;
      if (n !== e.lat) begin failures++; $display("FAIL match_latency got=%0d exp=%0d", n, e.lat); end
      checks++;
      if ({found, poly_index, offset} !== {e.f, e.idx, e.off}) begin
         failures++;
         $display("FAIL match_result got=%b/%0d/%0d exp=%b/%0d/%0d", found, poly_index, offset, e.f, e.idx, e.off);
      end
      @(posedge clk); #1;
      checks++;
      if ({busy, done, found, offset} !== {2'b00, e.f, e.off}) begin
         failures++;
         $display("FAIL match_after got=busy%b done%b off%0d exp=busy0 done0 off%0d", busy, done, offset, e.off);
      end
   endtask

   task automatic test_seed();
      exp_t e; int n;
      sb.push_back('{f:1'b1, idx:1'b0, off:4'h0, lat:2});
      accept(4'h1);
      wait_done(1, n);
      e = sb.pop_front();
      checks++;
      if (n !== e.lat) begin failures++; $display("FAIL seed_latency got=%0d exp=%0d", n, e.lat); end
      checks++;
      if ({found, poly_index, offset} !== {e.f, e.idx, e.off}) begin
         failures++;
         $display("FAIL seed_result got=%b/%0d/%0d exp=%b/%0d/%0d", found, poly_index, offset, e.f, e.idx, e.off);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_timeout();
      exp_t e; int n;
      sb.push_back('{f:1'b0, idx:1'b0, off:4'h0, lat:16});
      accept(4'h0);
      wait_done(1, n);
      e = sb.pop_front();
      checks++;
      if (n !== e.lat) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", n, e.lat); end
      checks++;
      if ({found, poly_index, offset} !== {e.f, e.idx, e.off}) begin
         failures++;
         $display("FAIL timeout_result got=%b/%0d/%0d exp=%b/%0d/%0d", found, poly_index, offset, e.f, e.idx, e.off);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_busy_ignore();
      exp_t e; int n; int extra;
      sb.push_back('{f:1'b1, idx:1'b0, off:4'hE, lat:16});
      accept(4'h8);
      repeat (3) begin @(posedge clk); #1; end
      data  = 4'h3;
      polys = 8'h99;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(5, n);
      e = sb.pop_front();
      checks++;
      if (n !== e.lat) begin failures++; $display("FAIL busy_latency got=%0d exp=%0d", n, e.lat); end
      checks++;
      if ({found, poly_index, offset} !== {e.f, e.idx, e.off}) begin
         failures++;
         $display("FAIL busy_result got=%b/%0d/%0d exp=%b/%0d/%0d", found, poly_index, offset, e.f, e.idx, e.off);
      end
      extra = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (busy !== 1'b0 || done !== 1'b0) extra++;
      end
      checks++;
      if (extra !== 0) begin failures++; $display("FAIL busy_no_requeue got=%0d exp=0 busy/done cycles", extra); end
      polys = 8'h0C;
   endtask

   task automatic test_reset_mid();
      exp_t e; int n; int pulses;
      accept(4'h8);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, found, poly_index, offset} !== 8'h00) begin
         failures++;
         $display("FAIL midreset_clear got=%b exp=%b", {busy, done, found, poly_index, offset}, 8'h00);
      end
      pulses = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (done !== 1'b0) pulses++;
      end
      rst = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) pulses++;
      end
      checks++;
      if (pulses !== 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", pulses); end
      sb.push_back('{f:1'b1, idx:1'b0, off:4'h6, lat:8});
      accept(4'hD);
      wait_done(1, n);
      e = sb.pop_front();
      checks++;
      if (n !== e.lat) begin failures++; $display("FAIL midreset_latency got=%0d exp=%0d", n, e.lat); end
      checks++;
      if ({found, poly_index, offset} !== {e.f, e.idx, e.off}) begin
         failures++;
         $display("FAIL midreset_result got=%b/%0d/%0d exp=%b/%0d/%0d", found, poly_index, offset, e.f, e.idx, e.off);
      end
      @(posedge clk); #1;
   endtask

`ifdef LFSR_SEARCH_ABORT_EN
   task automatic test_abort();
      exp_t e; int n;
      sb.push_back('{f:1'b0, idx:1'b0, off:4'h0, lat:5});
      accept(4'h8);
      repeat (3) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      wait_done(5, n);
      e = sb.pop_front();
      checks++;
      if (n !== e.lat) begin failures++; $display("FAIL abort_latency got=%0d exp=%0d", n, e.lat); end
      checks++;
      if ({found, poly_index, offset} !== {e.f, e.idx, e.off}) begin
         failures++;
         $display("FAIL abort_result got=%b/%0d/%0d exp=%b/%0d/%0d", found, poly_index, offset, e.f, e.idx, e.off);
      end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      data  = 4'h0;
      polys = 8'h0C;
      test_reset();
      test_match();
      test_seed();
      test_timeout();
      test_busy_ignore();
      test_reset_mid();
`ifdef LFSR_SEARCH_ABORT_EN
      test_abort();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
